// File: rtl/mips_mc_control.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mc_control
//  Description : Multicycle control unit for the MIPS execution unit.
//                Decodes the 6-bit opcode and sequences one instruction over
//                3-5 cycles. It drives the datapath controls RegDst, ALUSrc,
//                ALUOp, RegWrite and MemtoReg. It also drives the fetch,
//                memory-handshake and PC-update strobes around them.
//
//  Ports       : clk       - rising-edge clock
//                reset     - synchronous, active-high reset
//                Opcode    - Instruction[31:26] from the instruction register
//                Zero      - ALU zero flag from the EU (resolves beq)
//                MemReady  - RAM completion for the current read/write
//                RegDst .. PCSrc  - datapath / memory / PC control strobes
//                InstrDone - one-cycle pulse in the last state of each instr
//                Illegal   - sticky, unsupported opcode seen
//                Timeout   - sticky, memory wait exceeded TIMEOUT cycles
//                State     - current state encoding (debug)
//
//  Parameters  : TIMEOUT   - max consecutive MemReady=0 cycles in a memory
//                            state (0..255, 0 = wait forever)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_mc_control #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       RegDst,
    output logic       ALUSrc,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       MemtoReg,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MDRWrite,
    output logic       PCWrite,
    output logic       PCSrc,
    output logic       InstrDone,
    output logic       Illegal,
    output logic       Timeout,
    output logic [3:0] State
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;

    localparam logic [1:0] c_ALU_ADD   = 2'b00;
    localparam logic [1:0] c_ALU_SUB   = 2'b01;
    localparam logic [1:0] c_ALU_FUNCT = 2'b10;

    // Value the wait counter holds on the last permitted waiting cycle.
    // Only meaningful when the timeout is enabled.
    localparam logic       c_TO_EN     = (TIMEOUT != 0);
    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_WB_R   = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_WB_LW  = 4'd7,
        S_MEM_WR = 4'd8,
        S_BRANCH = 4'd9,
        S_HALT   = 4'd15
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t     state_q;
    logic [7:0] wait_cnt_q;
    logic       illegal_q;
    logic       timeout_q;

    // True when one more MemReady=0 cycle would exceed the allowed wait.
    logic       mem_wait_expired;

    assign mem_wait_expired = c_TO_EN && (wait_cnt_q == c_WAIT_LAST);

    // ------------------------------------------------------------------------
    // Sequencer: state, memory wait counter and sticky error flags.
    // The wait counter defaults to zero every cycle and only counts up while
    // a memory state keeps waiting. A state is therefore always entered with
    // a cleared counter.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 8'd0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= 8'd0;
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                end

                S_FETCH, S_MEM_RD, S_MEM_WR: begin
                    if (MemReady) begin
                        case (state_q)
                            S_FETCH:  state_q <= S_DECODE;
                            S_MEM_RD: state_q <= S_WB_LW;
                            default:  state_q <= S_FETCH;
                        endcase
                    end else if (mem_wait_expired) begin
                        state_q   <= S_HALT;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end

                S_DECODE: begin
                    case (Opcode)
                        c_OP_RTYPE:      state_q <= S_EXEC_R;
                        c_OP_LW, c_OP_SW: state_q <= S_ADDR;
                        c_OP_BEQ:        state_q <= S_BRANCH;
                        default: begin
                            state_q   <= S_HALT;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end

                S_EXEC_R: begin
                    state_q <= S_WB_R;
                end

                S_WB_R, S_WB_LW, S_BRANCH: begin
                    state_q <= S_FETCH;
                end

                // Opcode is re-sampled here to pick the memory direction.
                // An opcode that is no longer lw/sw cannot be completed.
                S_ADDR: begin
                    case (Opcode)
                        c_OP_LW: state_q <= S_MEM_RD;
                        c_OP_SW: state_q <= S_MEM_WR;
                        default: begin
                            state_q   <= S_HALT;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end

                S_HALT: begin
                    state_q <= S_HALT;
                end

                // Unused encodings park safely in HALT.
                default: begin
                    state_q <= S_HALT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output decode (Moore). Outputs are decoded from the state register.
    // The memory-completion strobes (IRWrite/PCWrite in FETCH, MDRWrite,
    // InstrDone in MEM_WR) and the branch PCWrite also qualify on
    // MemReady/Zero in the same cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        RegDst    = 1'b0;
        ALUSrc    = 1'b0;
        ALUOp     = c_ALU_ADD;
        RegWrite  = 1'b0;
        MemtoReg  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        MDRWrite  = 1'b0;
        PCWrite   = 1'b0;
        PCSrc     = 1'b0;
        InstrDone = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_EXEC_R: begin
                ALUOp = c_ALU_FUNCT;
            end
            S_WB_R: begin
                RegDst    = 1'b1;
                ALUOp     = c_ALU_FUNCT;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_ADDR: begin
                ALUSrc = 1'b1;
            end
            S_MEM_RD: begin
                ALUSrc   = 1'b1;
                MemRead  = 1'b1;
                MDRWrite = MemReady;
            end
            S_WB_LW: begin
                ALUSrc    = 1'b1;
                MemtoReg  = 1'b1;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_MEM_WR: begin
                ALUSrc    = 1'b1;
                MemWrite  = 1'b1;
                InstrDone = MemReady;
            end
            S_BRANCH: begin
                ALUOp     = c_ALU_SUB;
                PCSrc     = 1'b1;
                PCWrite   = Zero;
                InstrDone = 1'b1;
            end
            default: begin
                // IDLE, DECODE, HALT and unused encodings: everything low.
            end
        endcase
    end

    assign Illegal = illegal_q;
    assign Timeout = timeout_q;
    assign State   = state_q;

endmodule
`default_nettype wire
